// File: rtl/icmp_rx_sdpram_8x256_out_pipe.sv
// Optional output stage for the ICMP RX buffer RAM: one DATA_WIDTH register
// that shares the read pipeline's synchronous reset.
module sdpram_out_pipe #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/icmp_rx_sdpram_8x256.sv
// Simple dual-port RAM buffering received ICMP bytes: parser writes, reply builder
// reads with a registered read port (latency 1, or 2 with OUTPUT_REG).
module icmp_rx_sdpram_8x256 #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OUTPUT_REG = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;

    // Write-only process; memory is deliberately untouched by reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // First read register; reading the array here gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
        end else begin
            rd_q <= mem[rd_addr];
        end
    end

    generate
        if (OUTPUT_REG != 0) begin : g_out_reg
            sdpram_out_pipe #(
                .DATA_WIDTH(DATA_WIDTH)
            ) u_out_pipe (
                .clk(clk),
                .rst(rst),
                .d  (rd_q),
                .q  (rd_data)
            );
        end else begin : g_no_out_reg
            assign rd_data = rd_q;
        end
    endgenerate

endmodule

// File: tb/tb_icmp_rx_sdpram_8x256.sv
// Directed bench for the ICMP RX buffer RAM: one instance per OUTPUT_REG setting,
// driven with the same stimulus.
module tb_icmp_rx_sdpram_8x256;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_addr = 8'h00;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] rd_addr = 8'h00;
    logic [7:0] rd_data0;
    logic [7:0] rd_data1;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Reference state: byte array with per-address written flags, plus
    // expected outputs of the latency-1 and latency-2 instances.
    logic [7:0] m [256];
    bit         mv [256];
    logic [7:0] e0 = 8'h00;
    logic [7:0] e1 = 8'h00;
    bit         v0 = 1'b0;
    bit         v1 = 1'b0;

    always #5 clk = ~clk;

    icmp_rx_sdpram_8x256 #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .OUTPUT_REG(0)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data0)
    );

    icmp_rx_sdpram_8x256 #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .OUTPUT_REG(1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data1)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, step past the edge, update reference, compare.
    task automatic cyc(input logic r, input logic we, input logic [7:0] wa,
                       input logic [7:0] wd, input logic [7:0] ra, input string tag);
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd; rd_addr = ra;
        @(posedge clk);
        #1;
        if (r) begin
            e0 = 8'h00; v0 = 1'b1; e1 = 8'h00; v1 = 1'b1;
        end else begin
            e1 = e0; v1 = v0;
            e0 = m[ra]; v0 = mv[ra];
        end
        if (we) begin
            m[wa] = wd; mv[wa] = 1'b1;
        end
        if (v0) chk({tag, "_lat1"}, rd_data0, e0);
        if (v1) chk({tag, "_lat2"}, rd_data1, e1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            m[i] = 8'h00; mv[i] = 1'b0;
        end
        #2;

        // 1: reset with arbitrary read addresses
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b0, 8'h00, 8'h00, 8'((i * 37) + 5), "reset");
            chk("reset_zero0", rd_data0, 8'h00);
        end

        // 2: full fill then sequential read-back
        for (int a = 0; a < 256; a++)
            cyc(1'b0, 1'b1, 8'(a), 8'(8'hFF - a), 8'h00, "fill");
        for (int a = 0; a < 256; a++) begin
            cyc(1'b0, 1'b0, 8'h00, 8'h00, 8'(a), "read");
            chk("read_const0", rd_data0, 8'(8'hFF - a));
            if (a > 0) chk("read_const1", rd_data1, 8'(8'hFF - (a - 1)));
        end
        cyc(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, "flush");
        chk("read_last1", rd_data1, 8'h00);

        // 3: wr_en low must not write
        cyc(1'b0, 1'b0, 8'h10, 8'hAA, 8'h10, "gate");
        chk("gate0", rd_data0, 8'hEF);
        cyc(1'b0, 1'b0, 8'h10, 8'hAA, 8'h10, "gate_b");
        chk("gate1", rd_data1, 8'hEF);
        chk("gate0_again", rd_data0, 8'hEF);

        // 4: read-during-write on the same address returns old data
        cyc(1'b0, 1'b1, 8'h20, 8'h55, 8'h20, "rdw");
        chk("rdw_old0", rd_data0, 8'hDF);
        cyc(1'b0, 1'b0, 8'h00, 8'h00, 8'h20, "rdw_b");
        chk("rdw_new0", rd_data0, 8'h55);
        chk("rdw_old1", rd_data1, 8'hDF);
        cyc(1'b0, 1'b0, 8'h00, 8'h00, 8'h20, "rdw_c");
        chk("rdw_new1", rd_data1, 8'h55);

        // 5: one-cycle reset during a sequential read; memory retained
        cyc(1'b0, 1'b0, 8'h00, 8'h00, 8'h28, "mid");
        chk("mid_pre0", rd_data0, 8'hD7);
        cyc(1'b0, 1'b0, 8'h00, 8'h00, 8'h29, "mid");
        chk("mid_pre0b", rd_data0, 8'hD6);
        cyc(1'b1, 1'b0, 8'h00, 8'h00, 8'h2A, "mid_rst");
        chk("mid_rst0", rd_data0, 8'h00);
        chk("mid_rst1", rd_data1, 8'h00);
        cyc(1'b0, 1'b0, 8'h00, 8'h00, 8'h30, "mid_post");
        chk("mid_post0", rd_data0, 8'hCF);
        chk("mid_post1", rd_data1, 8'h00);
        cyc(1'b0, 1'b0, 8'h00, 8'h00, 8'h31, "mid_post_b");
        chk("mid_post1b", rd_data1, 8'hCF);
        chk("mid_post0b", rd_data0, 8'hCE);

        // Address wrap and independent ports on the same edge
        cyc(1'b0, 1'b1, 8'hFF, 8'h3C, 8'h01, "indep");
        chk("indep0", rd_data0, 8'hFE);
        cyc(1'b0, 1'b0, 8'h00, 8'h00, 8'hFF, "wrap");
        chk("wrap0", rd_data0, 8'h3C);
        cyc(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, "wrap_b");
        chk("wrap1", rd_data1, 8'h3C);
        chk("wrap0b", rd_data0, 8'hFF);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
